// File: rtl/score_pkg.sv
// Shared definitions for score_packer: FSM encodings, most-negative score helper
// and slot-counter width helper.
package score_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL = 2'd0;
  localparam state_t ST_PAD  = 2'd1;
  localparam state_t ST_DROP = 2'd2;

  localparam int SCORE_MAX_W = 256;

  // Sign bit set, all other bits clear; callers keep the low w bits.
  function automatic logic [SCORE_MAX_W-1:0] score_min(input int w);
    logic [SCORE_MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/score_packer.sv
// Packs a serial stream of signed scores into one flat frame vector for max_tree.
// Optional long-frame checking (err port, DROP state) under SCORE_PACKER_CHK_EN.
//
// state   | meaning
// FILL    | accepting real beats into the fill buffer
// PAD     | filling remaining slots of a short frame with the most-negative score
// DROP    | discarding overflow beats until s_last (checked builds only)
module score_packer
  import score_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pINPUT_NUM  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [pDATA_WIDTH-1:0]            s_data,
  input  logic                              s_last,
  output logic [pDATA_WIDTH*pINPUT_NUM-1:0] data_out,
  output logic                              en
`ifdef SCORE_PACKER_CHK_EN
  ,
  output logic                              err
`endif
);

  localparam int CW = cnt_width(pINPUT_NUM);
  localparam int FW = pDATA_WIDTH * pINPUT_NUM;
  localparam logic [SCORE_MAX_W-1:0] MIN_WIDE = score_min(pDATA_WIDTH);
  localparam logic [pDATA_WIDTH-1:0] MIN_VAL  = MIN_WIDE[pDATA_WIDTH-1:0];
  localparam logic [CW-1:0]          LAST_CNT = CW'(pINPUT_NUM - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [FW-1:0]   data_out_q, data_out_d;
  logic            en_q, en_d;
  logic            err_q, err_d;
  logic            accept;
  logic            last_slot;

  // Ready drops in the reset cycle itself because rst is an input here.
  assign s_ready   = rst && (state_q != ST_PAD);
  assign accept    = s_valid && s_ready;
  assign last_slot = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    data_out_d = data_out_q;
    en_d       = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          fill_d[int'(cnt_q)*pDATA_WIDTH +: pDATA_WIDTH] = s_data;
          if (last_slot) begin
            data_out_d = fill_d;
            cnt_d      = '0;
            en_d       = 1'b1;
`ifdef SCORE_PACKER_CHK_EN
            if (!s_last) begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (s_last) state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        fill_d[int'(cnt_q)*pDATA_WIDTH +: pDATA_WIDTH] = MIN_VAL;
        if (last_slot) begin
          data_out_d = fill_d;
          cnt_d      = '0;
          en_d       = 1'b1;
          state_d    = ST_FILL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef SCORE_PACKER_CHK_EN
      ST_DROP: begin
        if (accept && s_last) state_d = ST_FILL;
      end
`endif
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      fill_q     <= '0;
      data_out_q <= '0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      data_out_q <= data_out_d;
      en_q       <= en_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign en       = en_q;
`ifdef SCORE_PACKER_CHK_EN
  assign err      = err_q;
`endif

endmodule
